// File: rtl/serial_divider_if.sv
// Request/result bundle for serial_divider; master issues operands, slave returns results.
// Flow: start accepted only while idle; results flagged by a one-cycle Quotient_Valid.
interface serial_divider_if;
  logic        start;
  logic [15:0] in_dividend;
  logic [7:0]  in_divisor;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        Quotient_Valid;
  logic        Div_By_Zero;
  logic        busy;

  modport master (
    output start, in_dividend, in_divisor,
    input  Quotient, Remainder, Quotient_Valid, Div_By_Zero, busy
  );

  modport slave (
    input  start, in_dividend, in_divisor,
    output Quotient, Remainder, Quotient_Valid, Div_By_Zero, busy
  );
endinterface

// File: rtl/serial_divider.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle; result 17 cycles after accept (1 if divisor=0).
// No backpressure: start is ignored while busy, the result pulse cannot be stalled.
module serial_divider (
  input  logic            clk,
  input  logic            rst,
  serial_divider_if.slave div_if
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  p_q, p_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [15:0] quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        vld_q, vld_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;

  logic [8:0]  s;
  logic [8:0]  diff;
  logic        ge;

  always_comb begin
    // P never exceeds the divisor, so its top bit can be dropped when shifting.
    s    = 9'({p_q, sr_q[15]});
    diff = s - {1'b0, divisor_q};
    ge   = (s >= {1'b0, divisor_q});

    state_d   = state_q;
    p_d       = p_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    vld_d     = 1'b0;
    dbz_d     = dbz_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (div_if.start) begin
          divisor_d = div_if.in_divisor;
          sr_d      = div_if.in_dividend;
          p_d       = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          if (div_if.in_divisor == 8'd0) begin
            quot_d  = 16'hFFFF;
            rem_d   = div_if.in_dividend[7:0];
            dbz_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = ge ? diff : s;
        sr_d  = {sr_q[14:0], ge};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          quot_d  = sr_d;
          rem_d   = p_d[7:0];
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      vld_q     <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      vld_q     <= vld_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
    end
  end

  assign div_if.Quotient       = quot_q;
  assign div_if.Remainder      = rem_q;
  assign div_if.Quotient_Valid = vld_q;
  assign div_if.Div_By_Zero    = dbz_q;
  assign div_if.busy           = busy_q;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: directed vectors with hand-computed results,
// expectations queued at issue and popped by an independent result monitor.
module tb_serial_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_divider_if dif();
  serial_divider dut (.clk(clk), .rst(rst), .div_if(dif));

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  // Result monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && dif.Quotient_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got Quotient=%0d Remainder=%0d with nothing outstanding at cycle %0d",
                 dif.Quotient, dif.Remainder, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    32'(dif.Quotient),    32'(e.q));
        chk("remainder",   32'(dif.Remainder),   32'(e.r));
        chk("div_by_zero", 32'(dif.Div_By_Zero), 32'(e.dbz));
        chk("latency",     32'(cyc - e.t_acc),   e.dbz ? 32'd1 : 32'd17);
        chk("busy_at_valid", 32'(dif.busy),      32'd1);
      end
    end
  end

  // Presents operands for one cycle; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [15:0] dd, input logic [7:0] dv,
                       input logic [15:0] eq, input logic [7:0] er,
                       input bit push, output int t_acc);
    exp_t e;
    @(negedge clk);
    dif.start       = 1'b1;
    dif.in_dividend = dd;
    dif.in_divisor  = dv;
    t_acc           = cyc;
    @(posedge clk);
    #1;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = (dv == 8'd0); e.t_acc = t_acc;
      sb.push_back(e);
    end
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 40; k++) begin
      if (dif.busy === 1'b0) break;
      @(negedge clk);
    end
    if (k == 40) chk(nm, 32'(dif.busy), 32'd0);
  endtask

  localparam int NV = 13;
  logic [15:0] v_dd [NV] = '{16'hFFFF, 16'd5,   16'h1234, 16'd65535, 16'd0, 16'd255,
                             16'd300,  16'd65535, 16'd12345, 16'd40000, 16'h00AB, 16'd0, 16'd65534};
  logic [7:0]  v_dv [NV] = '{8'hFF,    8'd200,  8'd0,     8'd1,      8'd9,  8'd16,
                             8'd255,   8'd2,    8'd123,   8'd250,    8'd0,  8'd0,  8'd255};
  logic [15:0] v_q  [NV] = '{16'd257,  16'd0,   16'hFFFF, 16'd65535, 16'd0, 16'd15,
                             16'd1,    16'd32767, 16'd100, 16'd160,  16'hFFFF, 16'hFFFF, 16'd256};
  logic [7:0]  v_r  [NV] = '{8'd0,     8'd5,    8'h34,    8'd0,      8'd0,  8'd15,
                             8'd45,    8'd1,    8'd45,    8'd0,      8'hAB, 8'd0,  8'd254};

  initial begin
    int t;
    rst             = 1'b1;
    dif.start       = 1'b0;
    dif.in_dividend = '0;
    dif.in_divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient",  32'(dif.Quotient),       32'd0);
    chk("rst_remainder", 32'(dif.Remainder),      32'd0);
    chk("rst_valid",     32'(dif.Quotient_Valid), 32'd0);
    chk("rst_dbz",       32'(dif.Div_By_Zero),    32'd0);
    chk("rst_busy",      32'(dif.busy),           32'd0);
    rst = 1'b0;

    // Basic division, with a second start injected mid-run that must be ignored.
    issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b1, t);
    for (int k = 1; k <= 17; k++) begin
      chk("busy_run", 32'(dif.busy), 32'd1);
      if (k == 5) begin
        dif.start       = 1'b1;
        dif.in_dividend = 16'd50;
        dif.in_divisor  = 8'd5;
      end
      if (k == 6) dif.start = 1'b0;
      @(negedge clk);
    end
    chk("busy_after_done", 32'(dif.busy),     32'd0);
    chk("quotient_hold",   32'(dif.Quotient), 32'd142);
    chk("remainder_hold",  32'(dif.Remainder), 32'd6);

    // Directed vectors, including divide-by-zero and the 9-bit partial remainder corner.
    for (int i = 0; i < NV; i++) begin
      issue(v_dd[i], v_dv[i], v_q[i], v_r[i], 1'b1, t);
      chk("dbz_at_t1", 32'(dif.Div_By_Zero), (v_dv[i] == 8'd0) ? 32'd1 : 32'd0);
      wait_idle("idle_timeout");
      @(negedge clk);
    end

    // Reset mid-run aborts without a result.
    issue(16'd1000, 8'd7, 16'd0, 8'd0, 1'b0, t);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_quotient",  32'(dif.Quotient),       32'd0);
    chk("abort_remainder", 32'(dif.Remainder),      32'd0);
    chk("abort_valid",     32'(dif.Quotient_Valid), 32'd0);
    chk("abort_busy",      32'(dif.busy),           32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd200, 8'd3, 16'd66, 8'd2, 1'b1, t);
    wait_idle("idle_timeout_after_rst");

    // Start held high: back-to-back divisions 18 cycles apart.
    begin
      exp_t e;
      @(negedge clk);
      dif.start       = 1'b1;
      dif.in_dividend = 16'd100;
      dif.in_divisor  = 8'd10;
      t = cyc;
      e.q = 16'd10; e.r = 8'd0; e.dbz = 1'b0;
      e.t_acc = t;      sb.push_back(e);
      e.t_acc = t + 18; sb.push_back(e);
      repeat (19) @(posedge clk);
      @(negedge clk);
      dif.start = 1'b0;
    end

    for (int k = 0; k < 60 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) chk("drain_outstanding", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_divider.md
SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin a division, sampled on rising clk.
REQ-004 SHALL have port in_dividend, input, 16 bits: unsigned dividend, sampled when start is accepted.
REQ-005 SHALL have port in_divisor, input, 8 bits: unsigned divisor, sampled when start is accepted.
REQ-006 SHALL have port Quotient, output, 16 bits: unsigned quotient, registered.
REQ-007 SHALL have port Remainder, output, 8 bits: unsigned remainder, registered.
REQ-008 SHALL have port Quotient_Valid, output, 1 bit: one-cycle pulse marking a new result, registered.
REQ-009 SHALL have port Div_By_Zero, output, 1 bit: divisor was zero for the current result, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a division is in progress, registered.

Function
REQ-011 SHALL implement an FSM with three states, IDLE, RUN and DONE, held in state registers.
REQ-012 In IDLE with start=1 at edge T, SHALL latch both operands, set busy=1, clear Div_By_Zero, and enter RUN at T+1.
REQ-013 SHALL ignore start in RUN and DONE; operands latched at acceptance SHALL NOT change until the next acceptance.
REQ-014 SHALL use restoring shift-subtract: a 9-bit partial remainder P, a 16-bit dividend/quotient shift register, and a 4-bit iteration counter from 0 to 15.
REQ-015 Each RUN cycle SHALL form S={P[7:0],dividend_msb}, then shift the shift register left by one.
REQ-016 In the same RUN cycle, if S>=divisor, P SHALL become S-divisor and quotient LSB SHALL be 1; otherwise P SHALL become S and quotient LSB SHALL be 0.
REQ-017 All compares and subtracts SHALL be 9 bits wide, zero-extended, with no truncation of S.
REQ-018 After exactly 16 RUN cycles (counter 15 to wrap), SHALL load Quotient and Remainder=P[7:0] and enter DONE.
REQ-019 Quotient_Valid SHALL be 1 only in DONE (cycle T+17 after acceptance at T); DONE SHALL return to IDLE on the next edge.
REQ-020 busy SHALL be 1 from T+1 through the DONE cycle inclusive, and 0 in IDLE.
REQ-021 If in_divisor=0 at acceptance, SHALL skip RUN and enter DONE at T+1.
REQ-022 On that divide-by-zero path, SHALL set Quotient=16'hFFFF, Remainder=in_dividend[7:0], Div_By_Zero=1, and pulse Quotient_Valid.
REQ-023 Quotient, Remainder and Div_By_Zero SHALL hold their last values until the next result loads, including while IDLE and RUN.
REQ-024 start held high continuously SHALL begin a new division on the first IDLE cycle after DONE (minimum issue interval 18 cycles).
REQ-025 Result SHALL satisfy Quotient*divisor+Remainder == dividend and Remainder<divisor for every divisor!=0.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, busy=0, Quotient_Valid=0, Div_By_Zero=0, Quotient=0, Remainder=0, P=0 and counter=0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the division with no Quotient_Valid pulse; the first start after rst deasserts SHALL be handled normally.

Verification
REQ-028 dividend=1000, divisor=7, start pulse at T -> at T+17: Quotient=142, Remainder=6, Quotient_Valid=1 for one cycle, Div_By_Zero=0.
REQ-029 dividend=16'hFFFF, divisor=8'hFF -> Quotient=257, Remainder=0; dividend=5, divisor=200 -> Quotient=0, Remainder=5.
REQ-030 dividend=16'h1234, divisor=0 -> at T+1: Quotient=16'hFFFF, Remainder=8'h34, Div_By_Zero=1, Quotient_Valid=1.
REQ-031 start with new operands at T+5 during RUN -> ignored; the T+17 result matches the original operands; busy stays high T+1..T+17.
REQ-032 rst pulsed at T+8 mid-RUN -> all outputs 0, no valid pulse; a subsequent 200/3 request returns Quotient=66, Remainder=2.
REQ-033 Random regression of 10000 operand pairs, including divisor=1 and dividend=0 -> REQ-025 holds and latency is 17 cycles for every divisor!=0.
